pong_bounce_ctrl: RTL and testbench

- Closes the ball-motion loop. Watches the ball position from the position updater and produces the 4-bit direction vector {x[1:0], y[1:0]}, the enable, and the endgame flag that the updater consumes.
- Detects wall bounces, paddle hits and misses. Keeps both scores and runs the serve/play/point/game-over sequence.
- Sits between the ball position register, the two paddle position registers and the display/score logic.

---
 rtl/pong_pkg.sv | 28 ++
 rtl/pong_score_cnt.sv | 26 ++
 rtl/pong_bounce_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_pong_bounce_ctrl.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared encodings for the pong ball controller.
// Direction codes, FSM states, playfield defaults and paddle helper.
package pong_pkg;

    localparam int WIDTH_DEF        = 8;
    localparam int BIT_OF_WIDTH_DEF = 3;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b11;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        POINT,
        OVER
    } state_t;

    // Widened compare so paddle + len - 1 never wraps.
    function automatic logic paddle_covers(
        input logic [15:0] paddle,
        input logic [15:0] y,
        input logic [15:0] len
    );
        return (y >= paddle) && (y <= paddle + len - 16'd1);
    endfunction

endpackage

// File: rtl/pong_score_cnt.sv
// pong_score_cnt: 4-bit saturating score counter.
// win flags when the score equals WIN_SCORE.
module pong_score_cnt
    import pong_pkg::*;
#(
    parameter int WIN_SCORE = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [3:0] score,
    output logic       win
);

    // Count points, holding at 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= 4'd0;
        end else if (inc && (score != 4'hF)) begin
            score <= score + 4'd1;
        end
    end

    assign win = (score == 4'(WIN_SCORE));

endmodule

// File: rtl/pong_bounce_ctrl.sv
// pong_bounce_ctrl: ball direction, scoring and serve/play/point/over FSM.
// Optional macro PONG_SPIN_EN: paddle edge hits steer y direction.
module pong_bounce_ctrl
    import pong_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int BIT_OF_WIDTH = BIT_OF_WIDTH_DEF,
    parameter int PADDLE_LEN   = 3,
    parameter int WIN_SCORE    = 5,
    parameter int HOLD_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BIT_OF_WIDTH-1:0] x_pos,
    input  logic [BIT_OF_WIDTH-1:0] y_pos,
    input  logic [BIT_OF_WIDTH-1:0] paddle_l,
    input  logic [BIT_OF_WIDTH-1:0] paddle_r,
    input  logic                    serve,
    output logic [3:0]              vector,
    output logic                    en,
    output logic                    endgame,
    output logic [3:0]              score_l,
    output logic [3:0]              score_r
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [BIT_OF_WIDTH-1:0] POS_MAX =
        BIT_OF_WIDTH'(WIDTH - 1);
    localparam logic [BIT_OF_WIDTH-1:0] HIT_L_X =
        BIT_OF_WIDTH'(1);
    localparam logic [BIT_OF_WIDTH-1:0] HIT_R_X =
        BIT_OF_WIDTH'(WIDTH - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'(HOLD_CYCLES - 1);

    state_t state_q;
    state_t state_d;

    logic [3:0] vector_d;
    logic       en_d;
    logic       endgame_d;

    // 1 = right player lost the last point
    logic loser_r_q;
    logic loser_r_d;

    logic [2*BIT_OF_WIDTH-1:0] pos_q;
    logic [HOLD_W-1:0]         hold_q;
    logic [HOLD_W-1:0]         hold_d;

    logic       moved;
    logic       hit_l;
    logic       hit_r;
    logic       win_l;
    logic       win_r;
    logic       inc_l;
    logic       inc_r;
    logic [1:0] x_dir;
    logic [1:0] y_dir;
    logic [1:0] bx_dir;
    logic [1:0] by_dir;
    logic [1:0] serve_x;

    assign x_dir   = vector[3:2];
    assign y_dir   = vector[1:0];
    assign moved   = ({x_pos, y_pos} != pos_q);
    assign serve_x = loser_r_q ? DIR_POS : DIR_NEG;

`ifdef PONG_SPIN_EN
    localparam logic [BIT_OF_WIDTH:0] SPAN =
        (BIT_OF_WIDTH + 1)'(PADDLE_LEN - 1);

    logic [BIT_OF_WIDTH-1:0] hit_p;
    logic                    top;
    logic                    bot;
`endif

    // Wall and paddle bounce evaluation at the current ball position.
    always_comb begin
        hit_l = (x_pos == HIT_L_X) && (x_dir == DIR_NEG) &&
                paddle_covers(16'(paddle_l), 16'(y_pos),
                              16'(PADDLE_LEN));
        hit_r = (x_pos == HIT_R_X) && (x_dir == DIR_POS) &&
                paddle_covers(16'(paddle_r), 16'(y_pos),
                              16'(PADDLE_LEN));
        bx_dir = x_dir;
        by_dir = y_dir;
        if (hit_l) bx_dir = DIR_POS;
        if (hit_r) bx_dir = DIR_NEG;
        if ((y_pos == '0) && (y_dir == DIR_NEG)) begin
            by_dir = DIR_POS;
        end else if ((y_pos == POS_MAX) && (y_dir == DIR_POS)) begin
            by_dir = DIR_NEG;
        end
`ifdef PONG_SPIN_EN
        hit_p = hit_l ? paddle_l : paddle_r;
        top   = (hit_l || hit_r) && (y_pos == hit_p);
        bot   = (hit_l || hit_r) &&
                ({1'b0, y_pos} == ({1'b0, hit_p} + SPAN));
        if (top) begin
            by_dir = DIR_NEG;
        end else if (bot) begin
            by_dir = DIR_POS;
        end
        if (top || bot) begin
            if (y_pos == '0) begin
                by_dir = DIR_POS;
            end else if (y_pos == POS_MAX) begin
                by_dir = DIR_NEG;
            end
        end
`endif
    end

    // Next-state and registered-output logic for the game sequence.
    always_comb begin
        state_d   = state_q;
        vector_d  = vector;
        en_d      = 1'b0;
        endgame_d = 1'b0;
        loser_r_d = loser_r_q;
        hold_d    = hold_q;
        inc_l     = 1'b0;
        inc_r     = 1'b0;
        unique case (state_q)
            SERVE: begin
                vector_d = {serve_x, DIR_POS};
                if (serve) begin
                    state_d = PLAY;
                    en_d    = 1'b1;
                end
            end
            PLAY: begin
                en_d = 1'b1;
                if (moved) begin
                    if (x_pos == '0) begin
                        state_d   = POINT;
                        en_d      = 1'b0;
                        inc_r     = 1'b1;
                        loser_r_d = 1'b0;
                        hold_d    = '0;
                    end else if (x_pos == POS_MAX) begin
                        state_d   = POINT;
                        en_d      = 1'b0;
                        inc_l     = 1'b1;
                        loser_r_d = 1'b1;
                        hold_d    = '0;
                    end else begin
                        vector_d = {bx_dir, by_dir};
                    end
                end
            end
            POINT: begin
                vector_d = {serve_x, DIR_POS};
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (win_l || win_r) begin
                        state_d   = OVER;
                        endgame_d = 1'b1;
                    end else begin
                        state_d = SERVE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            OVER: begin
                vector_d  = {DIR_HOLD, DIR_HOLD};
                endgame_d = 1'b1;
            end
            default: state_d = SERVE;
        endcase
    end

    // State, outputs, position shadow and point hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SERVE;
            vector    <= {DIR_POS, DIR_POS};
            en        <= 1'b0;
            endgame   <= 1'b0;
            loser_r_q <= 1'b0;
            pos_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            vector    <= vector_d;
            en        <= en_d;
            endgame   <= endgame_d;
            loser_r_q <= loser_r_d;
            pos_q     <= {x_pos, y_pos};
            hold_q    <= hold_d;
        end
    end

    pong_score_cnt #(
        .WIN_SCORE (WIN_SCORE)
    ) u_score_l (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_l),
        .score (score_l),
        .win   (win_l)
    );

    pong_score_cnt #(
        .WIN_SCORE (WIN_SCORE)
    ) u_score_r (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_r),
        .score (score_r),
        .win   (win_r)
    );

endmodule

// File: tb/tb_pong_bounce_ctrl.sv
// tb_pong_bounce_ctrl: directed scenarios plus a randomized rally
// checked against a game-level reference model.
module tb_pong_bounce_ctrl;

    localparam int W    = 8;
    localparam int LEN  = 3;
    localparam int WIN  = 5;
    localparam int HOLD = 1024;

    localparam int PH_SERVE = 0;
    localparam int PH_PLAY  = 1;
    localparam int PH_POINT = 2;
    localparam int PH_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] x_pos = 3'd3;
    logic [2:0] y_pos = 3'd4;
    logic [2:0] paddle_l = 3'd0;
    logic [2:0] paddle_r = 3'd0;
    logic       serve = 1'b0;
    logic [3:0] vector;
    logic       en;
    logic       endgame;
    logic [3:0] score_l;
    logic [3:0] score_r;

    int n_checks = 0;
    int n_fail = 0;

    int m_phase;
    int m_dx;
    int m_dy;
    int m_sl;
    int m_sr;
    bit m_loser_left;
    int m_px;
    int m_py;
    int m_cyc;
    int m_point_end;

    pong_bounce_ctrl #(
        .WIDTH        (W),
        .BIT_OF_WIDTH (3),
        .PADDLE_LEN   (LEN),
        .WIN_SCORE    (WIN),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .paddle_l (paddle_l),
        .paddle_r (paddle_r),
        .serve    (serve),
        .vector   (vector),
        .en       (en),
        .endgame  (endgame),
        .score_l  (score_l),
        .score_r  (score_r)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input int d);
        return (d > 0) ? 2'b01 : 2'b11;
    endfunction

    function automatic logic [3:0] exp_vec();
        return {enc(m_dx), enc(m_dy)};
    endfunction

    task automatic model_reset();
        m_phase = PH_SERVE;
        m_dx = 1;
        m_dy = 1;
        m_sl = 0;
        m_sr = 0;
        m_loser_left = 1'b1;
        m_px = 0;
        m_py = 0;
        m_cyc = 0;
        m_point_end = 0;
    endtask

    // One clock of game rules, applied to the inputs about to be sampled.
    task automatic model_step();
        int x;
        int y;
        int ndx;
        int ndy;
        int hp;
        bit hit;
        x = int'(x_pos);
        y = int'(y_pos);
        case (m_phase)
            PH_SERVE: begin
                m_dx = m_loser_left ? -1 : 1;
                m_dy = 1;
                if (serve) m_phase = PH_PLAY;
            end
            PH_PLAY: begin
                if (x != m_px || y != m_py) begin
                    if (x == 0) begin
                        m_sr = (m_sr < 15) ? m_sr + 1 : 15;
                        m_loser_left = 1'b1;
                        m_phase = PH_POINT;
                        m_point_end = m_cyc + HOLD;
                    end else if (x == W - 1) begin
                        m_sl = (m_sl < 15) ? m_sl + 1 : 15;
                        m_loser_left = 1'b0;
                        m_phase = PH_POINT;
                        m_point_end = m_cyc + HOLD;
                    end else begin
                        ndx = m_dx;
                        ndy = m_dy;
                        hit = 1'b0;
                        hp = 0;
                        if (y == 0 && m_dy < 0) ndy = 1;
                        if (y == W - 1 && m_dy > 0) ndy = -1;
                        if (x == 1 && m_dx < 0 &&
                            y >= int'(paddle_l) &&
                            y < int'(paddle_l) + LEN) begin
                            ndx = 1;
                            hit = 1'b1;
                            hp = int'(paddle_l);
                        end
                        if (x == W - 2 && m_dx > 0 &&
                            y >= int'(paddle_r) &&
                            y < int'(paddle_r) + LEN) begin
                            ndx = -1;
                            hit = 1'b1;
                            hp = int'(paddle_r);
                        end
`ifdef PONG_SPIN_EN
                        if (hit && (y == hp || y == hp + LEN - 1)) begin
                            ndy = (y == hp) ? -1 : 1;
                            if (y == 0) ndy = 1;
                            if (y == W - 1) ndy = -1;
                        end
`endif
                        m_dx = ndx;
                        m_dy = ndy;
                    end
                end
            end
            PH_POINT: begin
                m_dx = m_loser_left ? -1 : 1;
                m_dy = 1;
                if (m_cyc == m_point_end) begin
                    if (m_sl == WIN || m_sr == WIN) begin
                        m_phase = PH_OVER;
                    end else begin
                        m_phase = PH_SERVE;
                    end
                end
            end
            default: ;
        endcase
        m_px = x;
        m_py = y;
        m_cyc++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        serve = 1'b0;
        x_pos = 3'd3;
        y_pos = 3'd4;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (vector !== 4'b0101) begin
            n_fail++;
            $display("FAIL reset_vector got=%b exp=0101", vector);
        end
        n_checks++;
        if (en !== 1'b0 || endgame !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_en_end got=%b%b exp=00", en, endgame);
        end
        n_checks++;
        if (score_l !== 4'd0 || score_r !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_scores got=%0d,%0d exp=0,0",
                     score_l, score_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (vector !== 4'b1101 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_idle got=%b en=%b exp=1101 en=0",
                     vector, en);
        end
    endtask

    task automatic test_serve_paddle();
        paddle_l = 3'd3;
        serve = 1'b1;
        step();
        serve = 1'b0;
        n_checks++;
        if (en !== 1'b1 || vector !== 4'b1101) begin
            n_fail++;
            $display("FAIL serve_start got=%b en=%b exp=1101 en=1",
                     vector, en);
        end
        x_pos = 3'd2;
        step();
        n_checks++;
        if (vector !== 4'b1101) begin
            n_fail++;
            $display("FAIL travel got=%b exp=1101", vector);
        end
        x_pos = 3'd1;
        step();
        n_checks++;
        if (vector !== 4'b0101) begin
            n_fail++;
            $display("FAIL paddle_l_hit got=%b exp=0101", vector);
        end
    endtask

    task automatic test_wall();
        x_pos = 3'd2; y_pos = 3'd5; step();
        x_pos = 3'd3; y_pos = 3'd6; step();
        x_pos = 3'd4; y_pos = 3'd7; step();
        n_checks++;
        if (vector !== 4'b0111) begin
            n_fail++;
            $display("FAIL wall_bottom got=%b exp=0111", vector);
        end
        step();
        step();
        n_checks++;
        if (vector !== 4'b0111) begin
            n_fail++;
            $display("FAIL still_hold got=%b exp=0111", vector);
        end
    endtask

    task automatic test_right_miss();
        x_pos = 3'd5; y_pos = 3'd6; step();
        x_pos = 3'd7; y_pos = 3'd5; step();
        n_checks++;
        if (en !== 1'b0 || score_l !== 4'd1) begin
            n_fail++;
            $display("FAIL right_miss got en=%b sl=%0d exp en=0 sl=1",
                     en, score_l);
        end
        serve = 1'b1;
        for (int i = 0; i < HOLD - 1; i++) step();
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_early_r got en=%b exp=0", en);
        end
        step();
        n_checks++;
        if (vector !== 4'b0101 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_r got=%b en=%b exp=0101 en=0",
                     vector, en);
        end
        step();
        serve = 1'b0;
        n_checks++;
        if (en !== 1'b1) begin
            n_fail++;
            $display("FAIL replay_r got en=%b exp=1", en);
        end
    endtask

    task automatic test_corner();
        paddle_r = 3'd5;
        x_pos = 3'd6; y_pos = 3'd7; step();
        n_checks++;
        if (vector !== 4'b1111) begin
            n_fail++;
            $display("FAIL corner got=%b exp=1111", vector);
        end
    endtask

    task automatic test_left_miss();
        paddle_l = 3'd0;
        x_pos = 3'd1; y_pos = 3'd6; step();
        n_checks++;
        if (vector !== 4'b1111) begin
            n_fail++;
            $display("FAIL paddle_l_miss got=%b exp=1111", vector);
        end
        x_pos = 3'd0; step();
        n_checks++;
        if (en !== 1'b0 || score_r !== 4'd1) begin
            n_fail++;
            $display("FAIL left_miss got en=%b sr=%0d exp en=0 sr=1",
                     en, score_r);
        end
        serve = 1'b1;
        for (int i = 0; i < HOLD - 1; i++) step();
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_early_l got en=%b exp=0", en);
        end
        step();
        n_checks++;
        if (vector !== 4'b1101) begin
            n_fail++;
            $display("FAIL serve_l got=%b exp=1101", vector);
        end
        step();
        serve = 1'b0;
        n_checks++;
        if (en !== 1'b1) begin
            n_fail++;
            $display("FAIL replay_l got en=%b exp=1", en);
        end
    endtask

    task automatic test_win_over();
        bit bad;
        for (int k = 2; k <= 5; k++) begin
            x_pos = 3'd5; y_pos = 3'd3; step();
            x_pos = 3'd7; step();
            n_checks++;
            if (score_l !== 4'(k) || en !== 1'b0) begin
                n_fail++;
                $display("FAIL win_score got=%0d en=%b exp=%0d en=0",
                         score_l, en, k);
            end
            serve = 1'b1;
            if (k < 5) begin
                for (int i = 0; i < HOLD + 1; i++) step();
                serve = 1'b0;
                n_checks++;
                if (en !== 1'b1 || endgame !== 1'b0) begin
                    n_fail++;
                    $display("FAIL win_replay got en=%b eg=%b exp 1 0",
                             en, endgame);
                end
            end
        end
        for (int i = 0; i < HOLD - 1; i++) step();
        n_checks++;
        if (endgame !== 1'b0) begin
            n_fail++;
            $display("FAIL endgame_early got=%b exp=0", endgame);
        end
        step();
        n_checks++;
        if (endgame !== 1'b1 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL endgame got eg=%b en=%b exp eg=1 en=0",
                     endgame, en);
        end
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (endgame !== 1'b1 || en !== 1'b0) bad = 1'b1;
        end
        serve = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL over_sticky got eg=%b en=%b exp eg=1 en=0",
                     endgame, en);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (score_l !== 4'd0 || score_r !== 4'd0 ||
            endgame !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear got sl=%0d sr=%0d eg=%b exp 0",
                     score_l, score_r, endgame);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_spin();
        logic [3:0] want;
`ifdef PONG_SPIN_EN
        want = 4'b1111;
`else
        want = 4'b1101;
`endif
        do_reset();
        paddle_l = 3'd0;
        paddle_r = 3'd0;
        x_pos = 3'd3; y_pos = 3'd4;
        serve = 1'b1;
        step();
        step();
        serve = 1'b0;
        x_pos = 3'd1; y_pos = 3'd1; step();
        n_checks++;
        if (vector !== 4'b0101) begin
            n_fail++;
            $display("FAIL spin_mid got=%b exp=0101", vector);
        end
        paddle_r = 3'd2;
        x_pos = 3'd6; y_pos = 3'd2; step();
        n_checks++;
        if (vector !== want) begin
            n_fail++;
            $display("FAIL spin_top got=%b exp=%b", vector, want);
        end
    endtask

    task automatic test_random();
        int x;
        int y;
        int over_cnt;
        do_reset();
        x = 3;
        y = 4;
        over_cnt = 0;
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 15) == 0)
                paddle_l = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0)
                paddle_r = 3'($urandom_range(0, 7));
            serve = ($urandom_range(0, 7) == 0);
            if (m_phase == PH_PLAY) begin
                if ($urandom_range(0, 2) != 0) begin
                    x = x + m_dx;
                    y = y + m_dy;
                    if (x < 0) x = 0;
                    if (x > W - 1) x = W - 1;
                    if (y < 0) y = 0;
                    if (y > W - 1) y = W - 1;
                end
            end else begin
                x = $urandom_range(3, 4);
                y = $urandom_range(0, 7);
            end
            x_pos = 3'(x);
            y_pos = 3'(y);
            step();
            n_checks++;
            if (en !== (m_phase == PH_PLAY)) begin
                n_fail++;
                $display("FAIL rand_en c=%0d got=%b exp=%b",
                         c, en, m_phase == PH_PLAY);
            end
            n_checks++;
            if (endgame !== (m_phase == PH_OVER)) begin
                n_fail++;
                $display("FAIL rand_endgame c=%0d got=%b exp=%b",
                         c, endgame, m_phase == PH_OVER);
            end
            n_checks++;
            if (score_l !== 4'(m_sl) || score_r !== 4'(m_sr)) begin
                n_fail++;
                $display("FAIL rand_score c=%0d got=%0d,%0d exp=%0d,%0d",
                         c, score_l, score_r, m_sl, m_sr);
            end
            if (m_phase == PH_SERVE || m_phase == PH_PLAY) begin
                n_checks++;
                if (vector !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rand_vector c=%0d got=%b exp=%b",
                             c, vector, exp_vec());
                end
            end
            if (m_phase == PH_OVER) over_cnt++;
            if (over_cnt > 20) begin
                over_cnt = 0;
                do_reset();
            end
        end
        serve = 1'b0;
    endtask

    initial begin
        test_reset();
        test_serve_paddle();
        test_wall();
        test_right_miss();
        test_corner();
        test_left_miss();
        test_win_over();
        test_spin();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
